xmr_probe_arbiter: RTL

- Shares one bound assertion checker between N probe requesters.
- Each requester is an XMR tap exported through a bind wire, e.g. a `_magma_bind_wire_*` net out of an inner instance.
- Arbitrates round-robin, captures the winner's probe value and source id, and offers it to the checker over a valid/ready handshake.
- Accumulates checker fail results: saturating fail count plus first-failing source.

---
 rtl/xmr_probe_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/xmr_probe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xmr_probe_arbiter
// Purpose  : Lets N probe requesters (XMR taps exported through bind wires,
//            e.g. _magma_bind_wire_* nets) share a single bound assertion
//            checker. Requests are arbitrated round-robin. The winner's probe
//            value and source id are captured and offered to the checker over
//            a valid/ready handshake. Checker fail results are accumulated
//            into a saturating fail count plus the first failing source.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N        number of probe requesters (2..16)
//   W        probe data width
//   CNT_W    fail counter width
//   TIMEOUT  starvation limit in cycles (starvation monitor only)
// Ports
//   CLK              in   rising-edge clock
//   ASYNCRESET       in   asynchronous active-high reset
//   req[N]           in   per-requester request, held until ack
//   data[N*W]        in   packed probe values, requester i at [i*W +: W]
//   ack[N]           out  one-hot one-cycle pulse after handshake
//   chk_valid        out  offer to checker
//   chk_ready        in   checker accepts offer
//   chk_data[W]      out  captured probe value
//   chk_src[SW]      out  source index of the offer
//   res_valid        in   checker result strobe
//   res_fail         in   result is a failure (qualified by res_valid)
//   fail_count[CNT_W] out saturating failure count
//   first_fail_src   out  source of the accepted offer at the first failure
//   first_fail_seen  out  sticky first-failure flag
//   busy             out  high while an offer is outstanding
//   starve           out  sticky starvation flag (0 without the monitor)
// Build option
//   XMR_PROBE_ARB_STARVE_EN  enables per-requester wait counters, the starve
//                            flag and a concurrent assertion that it never sets.
// ============================================================================
module xmr_probe_arbiter #(
  parameter  int N       = 4,
  parameter  int W       = 8,
  parameter  int CNT_W   = 8,
  parameter  int TIMEOUT = 64,
  localparam int SW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   data,
  output logic [N-1:0]     ack,
  output logic             chk_valid,
  input  logic             chk_ready,
  output logic [W-1:0]     chk_data,
  output logic [SW-1:0]    chk_src,
  input  logic             res_valid,
  input  logic             res_fail,
  output logic [CNT_W-1:0] fail_count,
  output logic [SW-1:0]    first_fail_src,
  output logic             first_fail_seen,
  output logic             busy,
  output logic             starve
);

  if (N < 2 || N > 16 || W < 1 || CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
    $error("xmr_probe_arbiter: parameter out of range");
  end

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [0:0]       r_state;
  logic [SW-1:0]    r_ptr;
  logic [N-1:0]     r_ack;
  logic             r_chk_valid;
  logic [W-1:0]     r_chk_data;
  logic [SW-1:0]    r_chk_src;
  logic [SW-1:0]    r_last_src;   // source of the most recently accepted offer
  logic [CNT_W-1:0] r_fail_count;
  logic [SW-1:0]    r_first_fail_src;
  logic             r_first_fail_seen;

  logic             w_any;
  logic [SW-1:0]    w_win;
  logic [W-1:0]     w_win_data;
  logic [N-1:0]     w_src_onehot;
  logic [SW-1:0]    w_next_ptr;

  // Index reached by stepping k places upward from p, wrapping at N.
  function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return SW'(s);
  endfunction

  // Scan from the farthest candidate down to ptr so the nearest set bit at
  // or after ptr is the last (and therefore winning) assignment.
  always_comb begin
    w_win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[rr_idx(r_ptr, k)]) w_win = rr_idx(r_ptr, k);
    end
  end

  assign w_any        = |req;
  assign w_win_data   = data[int'(w_win)*W +: W];
  assign w_src_onehot = N'(1) << r_chk_src;
  assign w_next_ptr   = (r_chk_src == SW'(N - 1)) ? '0 : r_chk_src + SW'(1);

  // Arbitration / offer FSM. After a handshake the FSM spends one cycle in
  // IDLE (the ack cycle), so transfers are at most one every two cycles.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_ack       <= '0;
      r_chk_valid <= 1'b0;
      r_chk_data  <= '0;
      r_chk_src   <= '0;
      r_last_src  <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_chk_data  <= w_win_data;
            r_chk_src   <= w_win;
            r_chk_valid <= 1'b1;
            r_state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          // The offer completes even if the requester has dropped req.
          if (chk_ready) begin
            r_ack       <= w_src_onehot;
            r_ptr       <= w_next_ptr;
            r_last_src  <= r_chk_src;
            r_chk_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result accounting. r_last_src is read before this edge's handshake
  // updates it, so a concurrent handshake is attributed to the prior offer.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_fail_count      <= '0;
      r_first_fail_src  <= '0;
      r_first_fail_seen <= 1'b0;
    end else if (res_valid && res_fail) begin
      if (r_fail_count != '1) r_fail_count <= r_fail_count + CNT_W'(1);
      if (!r_first_fail_seen) begin
        r_first_fail_seen <= 1'b1;
        r_first_fail_src  <= r_last_src;
      end
    end
  end

  assign ack             = r_ack;
  assign chk_valid       = r_chk_valid;
  assign chk_data        = r_chk_data;
  assign chk_src         = r_chk_src;
  assign fail_count      = r_fail_count;
  assign first_fail_src  = r_first_fail_src;
  assign first_fail_seen = r_first_fail_seen;
  assign busy            = (r_state == ST_OFFER);

`ifdef XMR_PROBE_ARB_STARVE_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wait [N];
  logic          r_starve;
  logic          w_hit;

  // A counter about to step onto TIMEOUT flags starvation on the same edge.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !r_ack[i] && (r_wait[i] >= TW'(TIMEOUT - 1))) w_hit = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      for (int i = 0; i < N; i++) r_wait[i] <= '0;
      r_starve <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || r_ack[i]) r_wait[i] <= '0;
        else if (r_wait[i] != TW'(TIMEOUT)) r_wait[i] <= r_wait[i] + TW'(1);
      end
      r_starve <= r_starve | w_hit;
    end
  end

  assign starve = r_starve;

  a_no_starve: assert property (@(posedge CLK) disable iff (ASYNCRESET) !starve);
`else
  assign starve = 1'b0;
`endif

endmodule
`default_nettype wire
